// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp -- multi-ported register file with a per-register busy
// scoreboard and a sequential hardware clear engine.
//
// Register 0 always reads as zero and ignores writes. Reads are
// combinational. With BYPASS=1, a read can see the data of a same-cycle write.
// A small FSM (IDLE -> CLEAR -> DONE) walks indices 1..NREGS-1 and zeroes
// one register plus its busy bit per cycle. While it runs, writes,
// scoreboard sets and new clear requests are ignored.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   we          [NWR]       per-port write enable
//   wa          [NWR*AW]    write addresses, port k at [k*AW +: AW]
//   wd          [NWR*XLEN]  write data, port k at [k*XLEN +: XLEN]
//   ra          [NRD*AW]    read addresses, port i at [i*AW +: AW]
//   rd          [NRD*XLEN]  read data, port i at [i*XLEN +: XLEN]
//   rd_busy     [NRD]       busy bit of each read address
//   bsy_set     mark bsy_addr as pending-write
//   bsy_addr    [AW]        scoreboard set address
//   clr_req     start a sequential clear
//   clr_active  high while the clear sequence runs
//   clr_done    one-cycle pulse after the last register is cleared
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*XLEN-1:0]  wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 bsy_set,
  input  logic [AW-1:0]        bsy_addr,
  input  logic                 clr_req,
  output logic                 clr_active,
  output logic                 clr_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);
  localparam bit            BYP_ON    = (BYPASS != 0);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             clr_active_q, clr_active_d;
  logic             clr_done_q, clr_done_d;
  logic             idle_s;

  // Writes, scoreboard sets and forwarding are only honoured in IDLE.
  assign idle_s = (state_q == ST_IDLE);

  // Clear sequencer next-state: index loads 1 on entry and saturates at the top.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = IDX_FIRST;
        end else begin
          idx_d   = idx_q;
        end
      end
      ST_CLEAR: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = IDX_FIRST;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_FIRST;
      end
    endcase
    clr_active_d = (state_d == ST_CLEAR);
    clr_done_d   = (state_d == ST_DONE);
  end

  // Register/scoreboard next-state: highest write port wins, set beats write-clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (idle_s) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (wa[k*AW +: AW] != '0)) begin
          regs_d[wa[k*AW +: AW]] = wd[k*XLEN +: XLEN];
          busy_d[wa[k*AW +: AW]] = 1'b0;
        end else begin
          busy_d = busy_d;
        end
      end
      if (bsy_set && (bsy_addr != '0)) begin
        busy_d[bsy_addr] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end else if (state_q == ST_CLEAR) begin
      regs_d[idx_q] = '0;
      busy_d[idx_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    // Entry 0 is hard-wired to zero.
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Read ports: array lookup, then optional same-cycle forwarding from write ports.
  always_comb begin : read_mux
    logic [AW-1:0]   a;
    logic [XLEN-1:0] val;
    logic            bsy;
    logic            hit;
    rd      = '0;
    rd_busy = '0;
    a       = '0;
    val     = '0;
    bsy     = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a   = ra[i*AW +: AW];
      val = regs_q[a];
      bsy = busy_q[a];
      hit = 1'b0;
      if (BYP_ON && idle_s && (a != '0)) begin
        // Ascending scan so the highest-index matching port ends up selected.
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (wa[k*AW +: AW] == a)) begin
            val = wd[k*XLEN +: XLEN];
            hit = 1'b1;
          end else begin
            hit = hit;
          end
        end
      end else begin
        hit = 1'b0;
      end
      // A pending write retires the busy bit unless a set lands on it too.
      if (hit && !(bsy_set && (bsy_addr == a))) begin
        bsy = 1'b0;
      end else begin
        bsy = bsy;
      end
      rd[i*XLEN +: XLEN] = val;
      rd_busy[i]         = bsy;
    end
  end

  // State, index, storage and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_FIRST;
      busy_q       <= '0;
      clr_active_q <= 1'b0;
      clr_done_q   <= 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      clr_active_q <= clr_active_d;
      clr_done_q   <= clr_done_d;
      regs_q       <= regs_d;
    end
  end

  assign clr_active = clr_active_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp -- self-checking bench for reg_file_mp.
// Instance dut:   defaults (XLEN=32, NREGS=32, NRD=2, NWR=2, BYPASS=1).
// Instance dut_b: XLEN=16, NREGS=8, NRD=3, NWR=1, BYPASS=0.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge, or 1ns after an input change within the same cycle.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic        bsy_set;
  logic [4:0]  bsy_addr;
  logic        clr_req, clr_active, clr_done;

  logic [0:0]  b_we;
  logic [2:0]  b_wa;
  logic [15:0] b_wd;
  logic [8:0]  b_ra;
  logic [47:0] b_rd;
  logic [2:0]  b_rd_busy;
  logic        b_bsy_set;
  logic [2:0]  b_bsy_addr;
  logic        b_clr_req, b_clr_active, b_clr_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic        mbusy [32];
  logic [31:0] fillv [32];

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rd_busy(rd_busy), .bsy_set(bsy_set), .bsy_addr(bsy_addr),
    .clr_req(clr_req), .clr_active(clr_active), .clr_done(clr_done)
  );

  reg_file_mp #(.XLEN(16), .NREGS(8), .NRD(3), .NWR(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd),
    .rd_busy(b_rd_busy), .bsy_set(b_bsy_set), .bsy_addr(b_bsy_addr),
    .clr_req(b_clr_req), .clr_active(b_clr_active), .clr_done(b_clr_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = '0; wa = '0; wd = '0; ra = '0; bsy_set = 1'b0; bsy_addr = '0; clr_req = 1'b0;
    b_we = '0; b_wa = '0; b_wd = '0; b_ra = '0; b_bsy_set = 1'b0; b_bsy_addr = '0; b_clr_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = 32'h0;
      mbusy[r] = 1'b0;
    end
  endtask

  task automatic fill_a();
    for (int a = 1; a < 32; a++) begin
      fillv[a] = $urandom | 32'h1;
      we = 2'b01; wa[4:0] = 5'(a); wd[31:0] = fillv[a];
      step();
    end
    we = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    for (int a = 0; a < 32; a += 5) begin
      ra[4:0] = 5'(a); ra[9:5] = 5'(31 - a);
      b_ra = {3'(a), 3'(a + 1), 3'(a + 2)};
      #1;
      checks++;
      if (rd !== 64'h0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read a=%0d: got rd=%h busy=%b expected 0", a, rd, rd_busy);
      end
      checks++;
      if (b_rd !== 48'h0 || b_rd_busy !== 3'b000) begin
        errors++;
        $display("FAIL reset_read_b a=%0d: got rd=%h busy=%b expected 0", a, b_rd, b_rd_busy);
      end
    end
    checks++;
    if (clr_active !== 1'b0 || clr_done !== 1'b0 || b_clr_active !== 1'b0 || b_clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %b%b%b%b expected 0000", clr_active, clr_done, b_clr_active, b_clr_done);
    end
    do_reset();
  endtask

  task automatic test_dual_write();
    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h22222222, 32'h11111111}; ra[4:0] = 5'd5;
    mid();
    checks++;
    if (rd[31:0] !== 32'h22222222) begin
      errors++;
      $display("FAIL dual_bypass: got %h expected 22222222", rd[31:0]);
    end
    step();
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFFFFFF}; ra = {5'd0, 5'd5};
    mid();
    checks++;
    if (rd[31:0] !== 32'h22222222) begin
      errors++;
      $display("FAIL dual_commit: got %h expected 22222222", rd[31:0]);
    end
    checks++;
    if (rd[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass: got %h expected 0", rd[63:32]);
    end
    step();
    we = 2'b00;
    mid();
    checks++;
    if (rd[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL x0_write: got %h expected 0", rd[63:32]);
    end
  endtask

  task automatic test_bypass();
    we = 2'b01; wa[4:0] = 5'd7; wd[31:0] = 32'h12345678;
    step();
    we = 2'b10; wa[9:5] = 5'd7; wd[63:32] = 32'hCAFEF00D; ra[4:0] = 5'd7;
    mid();
    checks++;
    if (rd[31:0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected cafef00d", rd[31:0]);
    end
    step();
    we = 2'b00;
    mid();
    checks++;
    if (rd[31:0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_commit: got %h expected cafef00d", rd[31:0]);
    end
    step();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    bsy_set = 1'b1; bsy_addr = 5'd9; ra[4:0] = 5'd9;
    mid();
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_before_edge: got %b expected 0", rd_busy[0]);
    end
    step();
    bsy_set = 1'b0;
    mid();
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set: got %b expected 1", rd_busy[0]);
    end
    we = 2'b01; wa[4:0] = 5'd9; wd[31:0] = 32'h99;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_write_forward: got %b expected 0", rd_busy[0]);
    end
    step();
    we = 2'b00;
    mid();
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_write_clear: got %b expected 0", rd_busy[0]);
    end
    step();
    bsy_set = 1'b1; bsy_addr = 5'd9; we = 2'b01; wa[4:0] = 5'd9;
    step();
    idle_inputs(); ra[4:0] = 5'd9;
    mid();
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: got %b expected 1", rd_busy[0]);
    end
    step();
    bsy_set = 1'b1; bsy_addr = 5'd0; ra[4:0] = 5'd0;
    step();
    bsy_set = 1'b0;
    mid();
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_x0: got %b expected 0", rd_busy[0]);
    end
    step();
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] ev;
    logic        eb, hit;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        wa[k*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wd[k*32 +: 32] = $urandom;
        ra[k*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      end
      bsy_set = 1'($urandom_range(0, 1));
      bsy_addr = 5'($urandom_range(0, 3));
      mid();
      for (int i = 0; i < 2; i++) begin
        a = ra[i*5 +: 5];
        ev = mregs[a];
        eb = mbusy[a];
        hit = 1'b0;
        if (a != 5'd0) begin
          for (int k = 0; k < 2; k++) begin
            if (we[k] && wa[k*5 +: 5] == a) begin
              ev = wd[k*32 +: 32];
              hit = 1'b1;
            end
          end
        end
        if (hit && !(bsy_set && bsy_addr == a)) eb = 1'b0;
        checks++;
        if (rd[i*32 +: 32] !== ev) begin
          errors++;
          $display("FAIL rand_rd cyc%0d port%0d a=%0d: got %h expected %h", n, i, a, rd[i*32 +: 32], ev);
        end
        checks++;
        if (rd_busy[i] !== eb) begin
          errors++;
          $display("FAIL rand_busy cyc%0d port%0d a=%0d: got %b expected %b", n, i, a, rd_busy[i], eb);
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        a = wa[k*5 +: 5];
        if (we[k] && a != 5'd0) begin
          mregs[a] = wd[k*32 +: 32];
          mbusy[a] = 1'b0;
        end
      end
      if (bsy_set && bsy_addr != 5'd0) mbusy[bsy_addr] = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int cnt;
    fill_a();
    bsy_set = 1'b1; bsy_addr = 5'd3;
    step();
    bsy_set = 1'b0; ra = {5'd3, 5'd17};
    mid();
    checks++;
    if (rd[31:0] !== fillv[17] || rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL clr_prefill: got %h/%b expected %h/1", rd[31:0], rd_busy[1], fillv[17]);
    end
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    we = 2'b01; wa[4:0] = 5'd5; wd[31:0] = 32'hDEADBEEF; ra[4:0] = 5'd5;
    cnt = 0;
    for (int g = 0; g < 100; g++) begin
      mid();
      if (!clr_active) break;
      cnt++;
      checks++;
      if (clr_done !== 1'b0) begin
        errors++;
        $display("FAIL clr_done_early cnt=%0d: got 1 expected 0", cnt);
      end
      if (cnt >= 6) begin
        checks++;
        if (rd[31:0] !== 32'h0) begin
          errors++;
          $display("FAIL clr_write_lost cnt=%0d: got %h expected 0", cnt, rd[31:0]);
        end
      end
      step();
    end
    checks++;
    if (cnt != 31) begin
      errors++;
      $display("FAIL clr_active_len: got %0d expected 31", cnt);
    end
    checks++;
    if (clr_done !== 1'b1 || rd[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL clr_done_pulse: got done=%b rd=%h expected 1/0", clr_done, rd[31:0]);
    end
    we = 2'b00;
    step();
    mid();
    checks++;
    if (clr_done !== 1'b0 || clr_active !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: got done=%b active=%b expected 0/0", clr_done, clr_active);
    end
    for (int r = 0; r < 32; r++) begin
      ra = {5'(r), 5'(r)};
      #1;
      checks++;
      if (rd !== 64'h0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL clr_zero x%0d: got %h/%b expected 0", r, rd, rd_busy);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_clear();
    fill_a();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    mid();
    checks++;
    if (clr_active !== 1'b1) begin
      errors++;
      $display("FAIL rmc_in_clear: got %b expected 1", clr_active);
    end
    rst_n = 1'b0;
    ra = {5'd20, 5'd31};
    #1;
    checks++;
    if (clr_active !== 1'b0 || clr_done !== 1'b0 || rd !== 64'h0) begin
      errors++;
      $display("FAIL rmc_immediate: got act=%b done=%b rd=%h expected 0", clr_active, clr_done, rd);
    end
    for (int r = 0; r < 32; r++) begin
      ra = {5'(r), 5'(r)};
      #1;
      checks++;
      if (rd !== 64'h0) begin
        errors++;
        $display("FAIL rmc_zero x%0d: got %h expected 0", r, rd);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    we = 2'b01; wa[4:0] = 5'd4; wd[31:0] = 32'hA5A5A5A5;
    step();
    we = 2'b00; ra[4:0] = 5'd4;
    mid();
    checks++;
    if (rd[31:0] !== 32'hA5A5A5A5 || clr_active !== 1'b0) begin
      errors++;
      $display("FAIL rmc_resume: got %h act=%b expected a5a5a5a5/0", rd[31:0], clr_active);
    end
    repeat (3) step();
    mid();
    checks++;
    if (clr_active !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL rmc_idle: got act=%b done=%b expected 0/0", clr_active, clr_done);
    end
    step();
  endtask

  task automatic test_sweep_rw();
    b_we = 1'b1; b_wa = 3'd5; b_wd = 16'h1111; b_ra = {3'd5, 3'd5, 3'd5};
    mid();
    checks++;
    if (b_rd !== 48'h0) begin
      errors++;
      $display("FAIL sw_no_bypass: got %h expected 0", b_rd);
    end
    step();
    b_wa = 3'd0; b_wd = 16'hFFFF;
    mid();
    checks++;
    if (b_rd !== 48'h111111111111) begin
      errors++;
      $display("FAIL sw_write: got %h expected 111111111111", b_rd);
    end
    step();
    b_we = 1'b0; b_ra[2:0] = 3'd0;
    mid();
    checks++;
    if (b_rd[15:0] !== 16'h0) begin
      errors++;
      $display("FAIL sw_x0: got %h expected 0", b_rd[15:0]);
    end
    b_we = 1'b1; b_wa = 3'd7; b_wd = 16'h1234;
    step();
    b_wd = 16'hCAFE; b_ra[2:0] = 3'd7;
    mid();
    checks++;
    if (b_rd[15:0] !== 16'h1234) begin
      errors++;
      $display("FAIL sw_old_value: got %h expected 1234", b_rd[15:0]);
    end
    step();
    b_we = 1'b0;
    mid();
    checks++;
    if (b_rd[15:0] !== 16'hCAFE) begin
      errors++;
      $display("FAIL sw_new_value: got %h expected cafe", b_rd[15:0]);
    end
    step();
  endtask

  task automatic test_sweep_sb_clear();
    int cnt;
    b_bsy_set = 1'b1; b_bsy_addr = 3'd3; b_ra[8:6] = 3'd3;
    step();
    b_bsy_set = 1'b0;
    mid();
    checks++;
    if (b_rd_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL sw_sb_set: got %b expected 1", b_rd_busy[2]);
    end
    b_we = 1'b1; b_wa = 3'd3; b_wd = 16'h0033;
    #1;
    checks++;
    if (b_rd_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL sw_sb_no_forward: got %b expected 1", b_rd_busy[2]);
    end
    step();
    b_we = 1'b0;
    mid();
    checks++;
    if (b_rd_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL sw_sb_clear: got %b expected 0", b_rd_busy[2]);
    end
    b_bsy_set = 1'b1; b_we = 1'b1;
    step();
    b_bsy_set = 1'b0; b_we = 1'b0;
    mid();
    checks++;
    if (b_rd_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL sw_sb_set_wins: got %b expected 1", b_rd_busy[2]);
    end
    step();
    for (int a = 1; a < 8; a++) begin
      b_we = 1'b1; b_wa = 3'(a); b_wd = 16'(16'h0100 + a);
      step();
    end
    b_we = 1'b0; b_ra = {3'd3, 3'd7, 3'd1};
    mid();
    checks++;
    if (b_rd !== {16'h0103, 16'h0107, 16'h0101}) begin
      errors++;
      $display("FAIL sw_fill: got %h expected 010301070101", b_rd);
    end
    step();
    b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    cnt = 0;
    for (int g = 0; g < 50; g++) begin
      mid();
      if (!b_clr_active) break;
      cnt++;
      step();
    end
    checks++;
    if (cnt != 7 || b_clr_done !== 1'b1) begin
      errors++;
      $display("FAIL sw_clear_len: got %0d done=%b expected 7/1", cnt, b_clr_done);
    end
    step();
    for (int r = 0; r < 8; r++) begin
      b_ra = {3'(r), 3'(r), 3'(r)};
      #1;
      checks++;
      if (b_rd !== 48'h0 || b_rd_busy !== 3'b000) begin
        errors++;
        $display("FAIL sw_clr_zero x%0d: got %h/%b expected 0", r, b_rd, b_rd_busy);
      end
    end
    step();
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_sweep_rw();
    test_sweep_sb_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of 2, at least 4; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning read-port count.
REQ-004 SHALL have parameter NWR, default 2, meaning write-port count.
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL have ports, one per line, as follows:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 we  in  NWR  per-port write enable
 wa  in  NWR*AW  write addresses, port k at bits [k*AW +: AW]
 wd  in  NWR*XLEN  write data, port k at bits [k*XLEN +: XLEN]
 ra  in  NRD*AW  read addresses
 rd  out  NRD*XLEN  read data
 rd_busy  out  NRD  scoreboard busy bit of each read address
 bsy_set  in  1  mark register bsy_addr as pending-write
 bsy_addr  in  AW  scoreboard set address
 clr_req  in  1  start sequential clear
 clr_active  out  1  clear sequence in progress
 clr_done  out  1  one-cycle pulse at end of clear

Function
REQ-007 SHALL implement reads combinationally; rd port i = register[ra i] with no clock latency.
REQ-008 SHALL return zero for register 0 on every read port; writes to address 0 SHALL be discarded.
REQ-009 SHALL commit writes at the rising clk edge for every port k with we[k]=1 and wa k nonzero.
REQ-010 SHALL, when several ports write the same address in one cycle, commit the data of the highest-index port.
REQ-011 SHALL, with BYPASS=1, drive rd i with wd of the highest-index port having we=1 and wa = ra i (nonzero) in that cycle; with BYPASS=0, rd i SHALL show the pre-edge value.
REQ-012 SHALL keep one busy bit per register; bit 0 is constant 0.
REQ-013 SHALL set busy[bsy_addr] at the clock edge when bsy_set=1 and bsy_addr nonzero.
REQ-014 SHALL clear busy[a] at the clock edge when any committed write targets a.
REQ-015 SHALL, when a set and a write hit the same address in one cycle, leave the bit set (set wins).
REQ-016 SHALL drive rd_busy i = busy[ra i] combinationally; with BYPASS=1, a same-cycle write to ra i SHALL force rd_busy i to 0 unless a set to that address occurs in the same cycle.
REQ-017 SHALL implement FSM states IDLE, CLEAR, DONE.
 IDLE -> CLEAR on clr_req=1; the index counter loads 1.
 In CLEAR, each cycle the FSM zeroes register[idx] and busy[idx], then increments idx.
 CLEAR -> DONE in the cycle after register NREGS-1 is cleared.
 DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL assert clr_active in CLEAR and clr_done only in DONE; the clear takes exactly NREGS-1 CLEAR cycles.
REQ-019 SHALL ignore we, bsy_set and clr_req while in CLEAR or DONE; reads stay functional, and bypass is disabled while clr_active=1.
REQ-020 SHALL NOT require the index counter to wrap; it saturates at NREGS-1 in CLEAR.

Reset
REQ-021 SHALL, on rst_n=0, asynchronously zero all registers and busy bits, force FSM to IDLE, load the index to 1, and drive clr_active=0 and clr_done=0.
REQ-022 SHALL abort an in-progress clear when reset asserts mid-sequence; after release the FSM is in IDLE.
REQ-023 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-024 Dual write: write port0 x5=0x11111111 and port1 x5=0x22222222 in the same cycle -> next cycle x5 reads 0x22222222; a write of 0xFFFFFFFF to x0 -> x0 reads 0.
REQ-025 Bypass: BYPASS=1, ra0=7 while port1 writes x7=0xCAFEF00D -> rd0=0xCAFEF00D in the same cycle; BYPASS=0 -> rd0 shows the old value until the next cycle.
REQ-026 Scoreboard: bsy_set x9 -> rd_busy=1 for ra=9 next cycle; write x9 -> rd_busy=0 after the edge; simultaneous set and write to x9 -> rd_busy stays 1.
REQ-027 Clear: fill x1..x31 with nonzero values, pulse clr_req -> clr_active high for exactly 31 cycles, then clr_done for 1 cycle, then all registers read 0; a write issued during clear is lost.
REQ-028 Reset mid-clear: assert rst_n=0 at CLEAR cycle 10 -> outputs zero immediately, all registers 0, FSM in IDLE after release.
REQ-029 Parameter sweep: NREGS=8, NRD=3, NWR=1, XLEN=16 passes REQ-024 to REQ-027 with widths scaled.
